// File: rtl/bcd_display_ctrl_pkg.sv
// Shared definitions for the BCD display controller.
//   state_t    : controller FSM states
//   SEG_BLANK  : active-low pattern with every segment off
//   ERR_DIGIT  : nibble shown on every display when the value does not fit
//   max_value  : largest decimal value representable in a given digit count
package bcd_display_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StUpdate  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ERR_DIGIT = 4'hE;

    // 10^digits - 1
    function automatic int unsigned max_value(input int unsigned digits);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to active-low seven-segment decoder.
//   digit : nibble to show
//   seg   : active-low segments, bit6 = a ... bit0 = g
module seven_segment
    import bcd_display_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0:      seg = 7'h01;
            4'h1:      seg = 7'h4F;
            4'h2:      seg = 7'h12;
            4'h3:      seg = 7'h06;
            4'h4:      seg = 7'h4C;
            4'h5:      seg = 7'h24;
            4'h6:      seg = 7'h20;
            4'h7:      seg = 7'h0F;
            4'h8:      seg = 7'h00;
            4'h9:      seg = 7'h04;
            4'hA:      seg = 7'h08;
            4'hB:      seg = 7'h60;
            4'hC:      seg = 7'h31;
            4'hD:      seg = 7'h42;
            ERR_DIGIT: seg = 7'h30;
            4'hF:      seg = 7'h38;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary to BCD converter (double-dabble, one bit per clock) driving seven-segment displays.
//   clk, rst : clock; asynchronous active-high reset
//   value    : binary input, sampled when a load is accepted
//   load     : start strobe, accepted only when idle and not busy
//   busy     : conversion in progress (through the done cycle)
//   done     : one-cycle pulse when new digits are on the outputs
//   overflow : displayed value exceeded 10^DIGITS-1
//   bcd_out  : latched BCD digits, [3:0] = ones
//   hex_out  : active-low segments per digit, [6:0] = ones
module bcd_display_ctrl
    import bcd_display_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(max_value(DIGITS));
    // Out of reset only the ones digit is visible when blanking is enabled.
    localparam logic [DIGITS-1:0] BLANK_RST = (BLANK_LZ != 0) ? ~DIGITS'(1) : '0;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_cap_q, ovf_cap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [DIGITS-1:0]  blank_q, blank_d;

    logic [BCD_W-1:0]   adj;
    logic [DIGITS-1:0]  lz_blank;
    logic               zero_run;
    logic [7*DIGITS-1:0] seg_raw;

    // Add-3 correction so every nibble stays decimal after the next shift.
    always_comb begin
        adj = acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is blanked when it and every higher digit are zero; ones digit never.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            zero_run    = zero_run & (acc_q[4*k +: 4] == 4'd0);
            lz_blank[k] = (BLANK_LZ != 0) && zero_run;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_cap_d  = ovf_cap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digits_d   = digits_q;
        blank_d    = blank_q;

        case (state_q)
            StIdle: begin
                // busy_q still high here marks the done cycle, where loads are dropped.
                busy_d = 1'b0;
                if (load && !busy_q) begin
                    bin_d     = value;
                    acc_d     = '0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    ovf_cap_d = (value > LIMIT);
                    busy_d    = 1'b1;
                    state_d   = StConvert;
                end
            end
            StConvert: begin
                {acc_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (ovf_cap_q) begin
                    digits_d   = {DIGITS{ERR_DIGIT}};
                    blank_d    = '0;
                    overflow_d = 1'b1;
                end else begin
                    digits_d   = acc_q;
                    blank_d    = lz_blank;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_cap_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= '0;
            blank_q    <= BLANK_RST;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_cap_q  <= ovf_cap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        seven_segment u_seg (
            .digit (digits_q[4*g +: 4]),
            .seg   (seg_raw[7*g +: 7])
        );
        assign hex_out[7*g +: 7] = blank_q[g] ? SEG_BLANK : seg_raw[7*g +: 7];
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = digits_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: one instance with leading-zero blanking, one without,
// sharing clock, reset and stimulus.
module tb_bcd_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = '0;
    logic        load = 1'b0;

    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic [27:0] hex_out;
    logic        busy_nb, done_nb, overflow_nb;
    logic [15:0] bcd_out_nb;
    logic [27:0] hex_out_nb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_display_ctrl #(.WIDTH(14), .DIGITS(4), .BLANK_LZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out),
        .hex_out  (hex_out)
    );

    bcd_display_ctrl #(.WIDTH(14), .DIGITS(4), .BLANK_LZ(0)) dut_nb (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy_nb),
        .done     (done_nb),
        .overflow (overflow_nb),
        .bcd_out  (bcd_out_nb),
        .hex_out  (hex_out_nb)
    );

    typedef struct {
        logic [13:0] value;
        logic [15:0] bcd;
        logic [27:0] hex;
        logic [27:0] hex_nb;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one load and wait (bounded) for done; lat counts edges after acceptance.
    task automatic run_conv(input logic [13:0] v, output int lat, output logic busy_seen);
        value = v;
        load  = 1'b1;
        tick();
        load      = 1'b0;
        lat       = 0;
        busy_seen = 1'b0;
        while (lat < 40) begin
            tick();
            lat++;
            if (lat == 1) busy_seen = busy;
            if (done) break;
        end
    endtask

    initial begin
        int   lat;
        logic bs;
        int   ndone;

        vecs[0] = '{14'd1234,  16'h1234, {7'h4F, 7'h12, 7'h06, 7'h4C},
                    {7'h4F, 7'h12, 7'h06, 7'h4C}, 1'b0};
        vecs[1] = '{14'd7,     16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h0F},
                    {7'h01, 7'h01, 7'h01, 7'h0F}, 1'b0};
        vecs[2] = '{14'd0,     16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h01},
                    {7'h01, 7'h01, 7'h01, 7'h01}, 1'b0};
        vecs[3] = '{14'd9999,  16'h9999, {4{7'h04}}, {4{7'h04}}, 1'b0};
        vecs[4] = '{14'd10000, 16'hEEEE, {4{7'h30}}, {4{7'h30}}, 1'b1};
        vecs[5] = '{14'd8888,  16'h8888, {4{7'h00}}, {4{7'h00}}, 1'b0};
        vecs[6] = '{14'd305,   16'h0305, {7'h7F, 7'h06, 7'h01, 7'h24},
                    {7'h01, 7'h06, 7'h01, 7'h24}, 1'b0};
        vecs[7] = '{14'd50,    16'h0050, {7'h7F, 7'h7F, 7'h24, 7'h01},
                    {7'h01, 7'h01, 7'h24, 7'h01}, 1'b0};
        vecs[8] = '{14'd16383, 16'hEEEE, {4{7'h30}}, {4{7'h30}}, 1'b1};
        vecs[9] = '{14'd5678,  16'h5678, {7'h24, 7'h20, 7'h0F, 7'h00},
                    {7'h24, 7'h20, 7'h0F, 7'h00}, 1'b0};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("reset hex", 32'(hex_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h01}));
        check("reset hex nb", 32'(hex_out_nb), 32'({4{7'h01}}));
        check("reset bcd", 32'(bcd_out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset overflow", 32'(overflow), 32'h0);

        // Table-driven conversions
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].value, lat, bs);
            check($sformatf("latency v=%0d", vecs[i].value), 32'(lat), 32'd15);
            check($sformatf("busy early v=%0d", vecs[i].value), 32'(bs), 32'h1);
            check($sformatf("done nb v=%0d", vecs[i].value), 32'(done_nb), 32'h1);
            check($sformatf("bcd v=%0d", vecs[i].value), 32'(bcd_out), 32'(vecs[i].bcd));
            check($sformatf("bcd nb v=%0d", vecs[i].value), 32'(bcd_out_nb),
                  32'(vecs[i].bcd));
            check($sformatf("hex v=%0d", vecs[i].value), 32'(hex_out), 32'(vecs[i].hex));
            check($sformatf("hex nb v=%0d", vecs[i].value), 32'(hex_out_nb),
                  32'(vecs[i].hex_nb));
            check($sformatf("ovf v=%0d", vecs[i].value), 32'(overflow), 32'(vecs[i].ovf));
            tick();
            check($sformatf("done pulse v=%0d", vecs[i].value), 32'(done), 32'h0);
            check($sformatf("busy after v=%0d", vecs[i].value), 32'(busy), 32'h0);
            check($sformatf("ovf hold v=%0d", vecs[i].value), 32'(overflow),
                  32'(vecs[i].ovf));
            value = 14'd3333;  // must not disturb held outputs
            tick();
            check($sformatf("hold bcd v=%0d", vecs[i].value), 32'(bcd_out), 32'(vecs[i].bcd));
        end

        // Loads while busy (cycle 3 and the done cycle) are dropped
        value = 14'd42;
        load  = 1'b1;
        tick();
        ndone = 0;
        for (int k = 1; k <= 16; k++) begin
            load  = (k - 1 == 3) || (k - 1 == 15);
            value = 14'd99;
            tick();
            if (done) ndone++;
        end
        load = 1'b0;
        check("ignored loads done count", 32'(ndone), 32'd1);
        check("ignored loads bcd", 32'(bcd_out), 32'h0042);
        check("ignored loads busy", 32'(busy), 32'h0);
        check("ignored loads done", 32'(done), 32'h0);
        run_conv(14'd99, lat, bs);
        check("load after done latency", 32'(lat), 32'd15);
        check("load after done busy", 32'(bs), 32'h1);
        check("load after done bcd", 32'(bcd_out), 32'h0099);
        tick();

        // Asynchronous reset in the middle of a conversion
        value = 14'd5678;
        load  = 1'b1;
        tick();
        load = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        check("midreset bcd", 32'(bcd_out), 32'h0);
        check("midreset hex", 32'(hex_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h01}));
        check("midreset hex nb", 32'(hex_out_nb), 32'({4{7'h01}}));
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("midreset no activity", 32'(ndone), 32'd0);
        run_conv(14'd5678, lat, bs);
        check("after reset latency", 32'(lat), 32'd15);
        check("after reset bcd", 32'(bcd_out), 32'h5678);
        check("after reset hex", 32'(hex_out), 32'({7'h24, 7'h20, 7'h0F, 7'h00}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
